viterbi_decoder: RTL and testbench

Hard-decision, 4-state Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code that the team's `encoder` block produces. It sits on the receive side of the tx/rx link. It takes one 2-bit code symbol per enabled cycle, which may contain channel bit errors, and emits one decoded data bit per enabled cycle after a fixed traceback latency. It uses add-compare-select (ACS) with Hamming branch metrics, normalised path metrics and register-exchange survivor memory.

---
 rtl/viterbi_decoder_if.sv | 8 +
 rtl/viterbi_decoder.sv | 56 +++++
 tb/tb_viterbi_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/viterbi_decoder_if.sv
// viterbi_decoder_if: symbol-in / decoded-bit-out link of the Viterbi decoder
interface viterbi_decoder_if;
    logic       enable;
    logic [1:0] d_in;
    logic       d_out;
    modport master (output enable, d_in, input d_out);
    modport slave (input enable, d_in, output d_out);
endinterface

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: 4-state hard-decision Viterbi decoder (rate 1/2, K=3, g=111/101), register-exchange survivors
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 7
) (
    input logic         clk,
    input logic         rst,
    viterbi_decoder_if.slave bus
);
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic                d_out_q, d_out_d;
    always_comb begin
        logic [PM_W-1:0]     cand [2];
        logic [PM_W-1:0]     npm [4];
        logic [TB_DEPTH-1:0] nsurv [4];
        logic [1:0]          best;
        logic                norm;
        cand  = '{default: '0};
        npm   = '{default: '0};
        nsurv = '{default: '0};
        for (int s = 0; s < 4; s++) begin
            // next state {u,a} from predecessor {a,p}; expected symbol {u^a^p, u^p}
            for (int p = 0; p < 2; p++)
                cand[p] = pm_q[{s[0], p[0]}]
                        + PM_W'(bus.d_in[1] ^ s[1] ^ s[0] ^ p[0])
                        + PM_W'(bus.d_in[0] ^ s[1] ^ p[0]);
            npm[s]   = cand[1] < cand[0] ? cand[1] : cand[0];
            nsurv[s] = {surv_q[{s[0], cand[1] < cand[0]}][TB_DEPTH-2:0], s[1]};
        end
        norm = npm[0][PM_W-1] & npm[1][PM_W-1] & npm[2][PM_W-1] & npm[3][PM_W-1];
        best = 2'd0;
        for (int i = 1; i < 4; i++)
            if (npm[i] < npm[best]) best = 2'(i);
        d_out_d = bus.enable ? nsurv[best][TB_DEPTH-1] : d_out_q;
        for (int s = 0; s < 4; s++) begin
            pm_d[s]   = bus.enable ? (norm ? {1'b0, npm[s][PM_W-2:0]} : npm[s]) : pm_q[s];
            surv_d[s] = bus.enable ? nsurv[s] : surv_q[s];
        end
    end
    // non-zero start metrics on states 1..3 pin the trellis to encoder state 00
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q    <= '{PM_W'(0), PM_W'(8), PM_W'(8), PM_W'(8)};
            surv_q  <= '{default: '0};
            d_out_q <= 1'b0;
        end else begin
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            d_out_q <= d_out_d;
        end
    end
    assign bus.d_out = d_out_q;
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: table-driven encoder model with expected-bit scoreboard for viterbi_decoder
module tb_viterbi_decoder;
    localparam int LAT = 15;
    typedef struct {
        logic u;
        logic en;
        logic flip;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    viterbi_decoder_if vif ();
    viterbi_decoder #(.TB_DEPTH(16), .PM_W(7)) dut (.clk(clk), .rst(rst), .bus(vif));
    always #5 clk = ~clk;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;
    logic [1:0] es;
    logic last_exp;
    logic hist[$];
    logic exp_q[$];
    vec_t tbl[$];
    logic [7:0] pat = 8'b01001101;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b0;
        vif.enable = 1'b0;
        vif.d_in = 2'b00;
        es = 2'b00;
        k = 0;
        last_exp = 1'b0;
        hist.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset d_out", 32'(vif.d_out), 0);
        check("reset pm3", 32'(dut.pm_q[3]), 8);
        rst = 1'b1;
    endtask
    task automatic step(input vec_t v, input string name);
        logic [1:0] sym;
        if (v.en) begin
            sym = {v.u ^ es[1] ^ es[0], v.u ^ es[0]};
            if (v.flip) sym[0] = ~sym[0];
            es = {v.u, es[1]};
            hist.push_back(v.u);
            last_exp = k >= LAT ? hist[k-LAT] : 1'b0;
            k++;
        end else begin
            sym = 2'($urandom);
        end
        exp_q.push_back(last_exp);
        vif.enable = v.en;
        vif.d_in = sym;
        @(posedge clk);
        #1;
        check(name, 32'(vif.d_out), 32'(exp_q.pop_front()));
    endtask
    task automatic run_table(input string name);
        foreach (tbl[i]) step(tbl[i], name);
        vif.enable = 1'b0;
    endtask
    task automatic load_pattern(input int n, input bit flips);
        tbl.delete();
        for (int i = 0; i < n; i++) tbl.push_back('{pat[i%8], 1'b1, flips && (i % 8 == 7)});
    endtask
    initial begin
        do_reset();
        tbl.delete();
        for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 1'b0});
        run_table("idle");
        check("idle pm0", 32'(dut.pm_q[0]), 0);
        check("idle pm1", 32'(dut.pm_q[1]), 8);
        do_reset();
        tbl.delete();
        for (int i = 0; i < 64; i++) tbl.push_back('{1'b0, 1'b1, 1'b0});
        run_table("zeros");
        check("zeros pm0", 32'(dut.pm_q[0]), 0);
        do_reset();
        load_pattern(64, 1'b0);
        run_table("pattern");
        do_reset();
        load_pattern(64, 1'b1);
        run_table("pattern_err");
        do_reset();
        tbl.delete();
        for (int i = 0; i < 256; i++) begin
            tbl.push_back('{1'($urandom), 1'b1, 1'b0});
            if (i % 2 == 1) tbl.push_back('{1'b0, 1'b0, 1'b0});
        end
        run_table("random_gaps");
        do_reset();
        load_pattern(40, 1'b0);
        run_table("pre_midrst");
        rst = 1'b0;
        #1;
        check("midrst d_out", 32'(vif.d_out), 0);
        check("midrst pm0", 32'(dut.pm_q[0]), 0);
        check("midrst pm2", 32'(dut.pm_q[2]), 8);
        do_reset();
        load_pattern(64, 1'b0);
        run_table("post_midrst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
